// File: rtl/row_ring_ctrl.sv
// Row ring-buffer controller: column/row addressing for a line-buffered window,
// with cyclic base row, registered vertical taps and a fill tracker.
module row_ring_ctrl #(
  parameter int ROW_BITS  = 4,
  parameter int COL_BITS  = 10,
  parameter int TAPS      = 3,
  parameter int DEF_ROWS  = 4,
  parameter int DEF_WIDTH = 640
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic [ROW_BITS-1:0]      cfg_rows,
  input  logic [COL_BITS-1:0]      cfg_width,
  input  logic                     dir,
  input  logic                     pixel_valid,
  output logic [COL_BITS-1:0]      col_addr,
  output logic [ROW_BITS-1:0]      base_row,
  output logic [TAPS*ROW_BITS-1:0] tap_rows,
  output logic                     row_done,
  output logic                     window_valid,
  output logic                     cfg_err
);

  localparam int RW = ROW_BITS + 1;
  localparam int FW = $clog2(TAPS + 1);

  logic [ROW_BITS-1:0]      rows_q;
  logic [COL_BITS-1:0]      width_q;
  logic                     dir_q;
  logic [FW-1:0]            filled;
  logic                     wrap;
  logic [ROW_BITS-1:0]      base_nxt;

  // Legal rings must hold all taps plus the row currently being written.
  function automatic logic cfg_ok(input logic [ROW_BITS-1:0] rows,
                                  input logic [COL_BITS-1:0] width);
    return (int'(rows) >= TAPS + 1) && (rows != '0) && (width != '0);
  endfunction

  function automatic logic [ROW_BITS-1:0] ring_step(input logic [ROW_BITS-1:0] base,
                                                    input logic [ROW_BITS-1:0] rows,
                                                    input logic              dn);
    logic [RW-1:0] r;
    logic [RW-1:0] s;
    r = {1'b0, rows};
    if (dn) begin
      s = (base == '0) ? r - RW'(1) : {1'b0, base} - RW'(1);
    end else begin
      s = {1'b0, base} + RW'(1);
      if (s >= r) s = '0;
    end
    return s[ROW_BITS-1:0];
  endfunction

  // Taps point at completed rows, i.e. behind base_row in the ring direction.
  // For legal configs every offset lies within one ring turn, so a single
  // conditional subtract is enough.
  function automatic logic [TAPS*ROW_BITS-1:0] taps_of(input logic [ROW_BITS-1:0] base,
                                                       input logic [ROW_BITS-1:0] rows,
                                                       input logic              dn);
    logic [TAPS*ROW_BITS-1:0] t;
    logic [RW-1:0]            r;
    logic [RW-1:0]            s;
    t = '0;
    r = {1'b0, rows};
    for (int k = 0; k < TAPS; k++) begin
      if (dn) s = {1'b0, base} + RW'(k + 1);
      else    s = {1'b0, base} + r - RW'(k + 1);
      if (s >= r) s = s - r;
      t[k*ROW_BITS +: ROW_BITS] = s[ROW_BITS-1:0];
    end
    return t;
  endfunction

  always_comb begin
    wrap     = pixel_valid && !cfg_err && (col_addr == width_q - COL_BITS'(1));
    base_nxt = ring_step(base_row, rows_q, dir_q);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rows_q   <= ROW_BITS'(DEF_ROWS);
      width_q  <= COL_BITS'(DEF_WIDTH);
      dir_q    <= 1'b0;
      col_addr <= '0;
      base_row <= '0;
      tap_rows <= taps_of('0, ROW_BITS'(DEF_ROWS), 1'b0);
      filled   <= '0;
      row_done <= 1'b0;
      cfg_err  <= !cfg_ok(ROW_BITS'(DEF_ROWS), COL_BITS'(DEF_WIDTH));
    end else if (clear) begin
      rows_q   <= cfg_rows;
      width_q  <= cfg_width;
      dir_q    <= dir;
      col_addr <= '0;
      base_row <= '0;
      tap_rows <= taps_of('0, cfg_rows, dir);
      filled   <= '0;
      row_done <= 1'b0;
      cfg_err  <= !cfg_ok(cfg_rows, cfg_width);
    end else begin
      row_done <= wrap;
      if (pixel_valid && !cfg_err) begin
        if (wrap) begin
          col_addr <= '0;
          base_row <= base_nxt;
          tap_rows <= taps_of(base_nxt, rows_q, dir_q);
          if (filled != FW'(TAPS)) filled <= filled + FW'(1);
        end else begin
          col_addr <= col_addr + COL_BITS'(1);
        end
      end
    end
  end

  assign window_valid = (filled == FW'(TAPS));

endmodule

// File: tb/tb_row_ring_ctrl.sv
// Scoreboard bench for row_ring_ctrl: directed rows push hand-computed
// expectations; a negedge monitor checks each row_done pulse against them.
module tb_row_ring_ctrl;

  localparam int RB = 4;
  localparam int CB = 10;
  localparam int TP = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear;
  logic [RB-1:0] cfg_rows;
  logic [CB-1:0] cfg_width;
  logic          dir;
  logic          pixel_valid;
  logic [CB-1:0] col_addr;
  logic [RB-1:0] base_row;
  logic [TP*RB-1:0] tap_rows;
  logic          row_done;
  logic          window_valid;
  logic          cfg_err;

  typedef struct packed {
    logic [RB-1:0]    base;
    logic [TP*RB-1:0] taps;
    logic             wv;
  } row_exp_t;

  row_exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  row_ring_ctrl #(.ROW_BITS(RB), .COL_BITS(CB), .TAPS(TP), .DEF_ROWS(4), .DEF_WIDTH(640)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .cfg_rows(cfg_rows), .cfg_width(cfg_width),
    .dir(dir), .pixel_valid(pixel_valid), .col_addr(col_addr), .base_row(base_row),
    .tap_rows(tap_rows), .row_done(row_done), .window_valid(window_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Monitor: every row_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (row_done === 1'b1) begin
      row_exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL row_done_unexpected: base=%0d taps=%h wv=%0b, no row expected",
                 base_row, tap_rows, window_valid);
      end else begin
        e = exp_q.pop_front();
        if (base_row !== e.base || tap_rows !== e.taps || window_valid !== e.wv) begin
          n_fail++;
          $display("FAIL row_result: got base=%0d taps=%h wv=%0b, want base=%0d taps=%h wv=%0b",
                   base_row, tap_rows, window_valid, e.base, e.taps, e.wv);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic exp_row(input int b, input int t2, input int t1, input int t0, input bit wv);
    row_exp_t e;
    e.base = RB'(b);
    e.taps = {RB'(t2), RB'(t1), RB'(t0)};
    e.wv   = wv;
    exp_q.push_back(e);
  endtask

  task automatic pix(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_clear(input int rows, input int width, input bit d, input bit pv);
    cfg_rows    = RB'(rows);
    cfg_width   = CB'(width);
    dir         = d;
    clear       = 1'b1;
    pixel_valid = pv;
    @(posedge clk); #1;
    clear       = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col"},  32'(col_addr), 0);
    check({tag, "_base"}, 32'(base_row), 0);
    check({tag, "_taps"}, 32'(tap_rows), 32'h123);
    check({tag, "_rd"},   32'(row_done), 0);
    check({tag, "_wv"},   32'(window_valid), 0);
    check({tag, "_err"},  32'(cfg_err), 0);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; pixel_valid = 1'b0;
    cfg_rows = '0; cfg_width = '0; dir = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_rst = 1'b1;
    check_reset_state("reset");

    // Default 640-pixel row.
    exp_row(1, 2, 3, 0, 1'b0);
    pix(640, 0);
    check("def_row_col", 32'(col_addr), 0);

    // rows=4 width=2 up, gapped pixels; window fills on third row.
    do_clear(4, 2, 1'b0, 1'b0);
    check("clr4_taps", 32'(tap_rows), 32'h123);
    check("clr4_err",  32'(cfg_err), 0);
    exp_row(1, 2, 3, 0, 1'b0);
    exp_row(2, 3, 0, 1, 1'b0);
    exp_row(3, 0, 1, 2, 1'b1);
    exp_row(0, 1, 2, 3, 1'b1);
    pix(8, 1);
    check("clr4_wv_end", 32'(window_valid), 1);

    // clear beats a pixel arriving at the last column.
    pix(1, 0);
    check("pre_clr_col", 32'(col_addr), 1);
    do_clear(4, 2, 1'b0, 1'b1);
    check("clrpix_col", 32'(col_addr), 0);
    check("clrpix_rd",  32'(row_done), 0);
    check("clrpix_wv",  32'(window_valid), 0);
    exp_row(1, 2, 3, 0, 1'b0);
    pix(2, 0);

    // rows=5 width=3 down.
    do_clear(5, 3, 1'b1, 1'b0);
    check("dn_taps0", 32'(tap_rows), 32'h321);
    exp_row(4, 2, 1, 0, 1'b0);
    exp_row(3, 1, 0, 4, 1'b0);
    pix(6, 0);

    // Illegal ring depth freezes everything; cfg changes without clear ignored.
    do_clear(3, 2, 1'b0, 1'b0);
    check("bad_err", 32'(cfg_err), 1);
    pix(10, 0);
    check("bad_col",  32'(col_addr), 0);
    check("bad_base", 32'(base_row), 0);
    cfg_rows = RB'(8); cfg_width = CB'(5);
    @(posedge clk); #1;
    check("bad_err_hold", 32'(cfg_err), 1);

    // One-pixel rows: row_done on consecutive cycles.
    do_clear(4, 1, 1'b0, 1'b0);
    check("w1_err", 32'(cfg_err), 0);
    exp_row(1, 2, 3, 0, 1'b0);
    exp_row(2, 3, 0, 1, 1'b0);
    exp_row(3, 0, 1, 2, 1'b1);
    exp_row(0, 1, 2, 3, 1'b1);
    pix(4, 0);

    // Reset mid-row overrides clear and pixels.
    do_clear(5, 4, 1'b1, 1'b0);
    pix(2, 1);
    check("mid_col", 32'(col_addr), 2);
    n_rst = 1'b0; clear = 1'b1; pixel_valid = 1'b1; cfg_width = CB'(1);
    @(posedge clk); #1;
    n_rst = 1'b1; clear = 1'b0; pixel_valid = 1'b0;
    check_reset_state("midrst");
    exp_row(1, 2, 3, 0, 1'b0);
    pix(640, 0);

    repeat (3) begin @(posedge clk); #1; end
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
